// File: rtl/spi_bus_arbiter_if.sv
// Bundle of requester, spi_master and device chip-select signals around the SPI bus arbiter.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface spi_bus_arbiter_if #(
    parameter int NUM_REQ         = 3,
    parameter int MOSI_DATA_WIDTH = 24,
    parameter int MISO_DATA_WIDTH = 8
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]                 req;
    logic [NUM_REQ-1:0]                 gnt;
    logic [NUM_REQ-1:0]                 req_wr_cmd;
    logic [NUM_REQ-1:0]                 req_rd_cmd;
    logic [NUM_REQ*MOSI_DATA_WIDTH-1:0] req_wr_data;
    logic [NUM_REQ-1:0]                 req_busy;
    logic [MISO_DATA_WIDTH:0]           req_rd_data;
    logic                               spi_wr_cmd;
    logic                               spi_rd_cmd;
    logic [MOSI_DATA_WIDTH-1:0]         spi_wr_data;
    logic                               spi_busy;
    logic [MISO_DATA_WIDTH:0]           spi_rd_data;
    logic                               spi_ncs;
    logic [NUM_REQ-1:0]                 dev_cs_n;
    logic [OW-1:0]                      owner;
    logic                               cmd_drop_err;

    modport slave (
        input  req, req_wr_cmd, req_rd_cmd, req_wr_data,
        input  spi_busy, spi_rd_data, spi_ncs,
        output gnt, req_busy, req_rd_data,
        output spi_wr_cmd, spi_rd_cmd, spi_wr_data,
        output dev_cs_n, owner, cmd_drop_err
    );

    modport master (
        output req, req_wr_cmd, req_rd_cmd, req_wr_data,
        output spi_busy, spi_rd_data, spi_ncs,
        input  gnt, req_busy, req_rd_data,
        input  spi_wr_cmd, spi_rd_cmd, spi_wr_data,
        input  dev_cs_n, owner, cmd_drop_err
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin, burst-safe arbiter sharing one spi_master between the device config sequencers,
// with chip-select steering to the owner's device and a guard gap between owners.
module spi_bus_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int MOSI_DATA_WIDTH = 24,
    parameter int MISO_DATA_WIDTH = 8,
    parameter int GUARD_CYCLES    = 4
) (
    input  logic              clk_20m,
    input  logic              rstn,
    spi_bus_arbiter_if.slave  bus
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, OWN, DRAIN, GUARD} state_t;

    state_t               state_q, state_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [3:0]           guard_q, guard_d;
    logic                 err_q, err_d;

    logic [NUM_REQ-1:0]         ownSel;
    logic                       ownReq, ownWr, ownRd, otherCmd, dropCmd;
    logic [MOSI_DATA_WIDTH-1:0] ownData;
    logic [MISO_DATA_WIDTH:0]   rdData;

    // Decode the registered owner into a one-hot select and pick out its request lines.
    always_comb begin
        ownSel   = '0;
        ownReq   = 1'b0;
        ownWr    = 1'b0;
        ownRd    = 1'b0;
        ownData  = '0;
        otherCmd = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == OW'(i)) begin
                ownSel[i] = 1'b1;
                ownReq    = bus.req[i];
                ownWr     = bus.req_wr_cmd[i];
                ownRd     = bus.req_rd_cmd[i];
                ownData   = bus.req_wr_data[i*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
            end else begin
                otherCmd  = otherCmd | bus.req_wr_cmd[i] | bus.req_rd_cmd[i];
            end
        end
    end

    always_comb begin
        int  idx;
        logic found;
        state_d = state_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        guard_d = guard_q;
        idx     = 0;
        found   = 1'b0;
        case (state_q)
            IDLE: begin
                // Search starts one past the last owner so a returning owner goes to the back.
                for (int k = 1; k <= NUM_REQ; k++) begin
                    idx = (int'(owner_q) + k) % NUM_REQ;
                    if (!found && bus.req[idx]) begin
                        found   = 1'b1;
                        owner_d = OW'(idx);
                    end
                end
                if (found) begin
                    state_d = OWN;
                    gnt_d   = NUM_REQ'(1) << owner_d;
                end
            end
            OWN: begin
                if (!ownReq) begin
                    gnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.spi_busy) begin
                    guard_d = 4'(GUARD_CYCLES);
                    state_d = GUARD;
                end
            end
            GUARD: begin
                guard_d = guard_q - 4'd1;
                if (guard_q <= 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Any command that cannot reach spi_master unchanged latches the sticky drop flag.
    always_comb begin
        dropCmd = otherCmd;
        if (state_q == OWN) begin
            if ((ownWr || ownRd) && bus.spi_busy) dropCmd = 1'b1;
            if (ownWr && ownRd)                   dropCmd = 1'b1;
        end else if (ownWr || ownRd) begin
            dropCmd = 1'b1;
        end
        err_d = err_q | dropCmd;
    end

    always_comb begin
        bus.spi_wr_cmd  = 1'b0;
        bus.spi_rd_cmd  = 1'b0;
        bus.spi_wr_data = '0;
        bus.dev_cs_n    = '1;
        bus.req_busy    = '1;
        if (state_q == OWN) begin
            bus.spi_wr_cmd  = ownWr & ~bus.spi_busy;
            bus.spi_rd_cmd  = ownRd & ~ownWr & ~bus.spi_busy;
            bus.spi_wr_data = ownData;
        end
        if (state_q == OWN || state_q == DRAIN) begin
            bus.dev_cs_n = ~ownSel | {NUM_REQ{bus.spi_ncs}};
            bus.req_busy = ~ownSel | {NUM_REQ{bus.spi_busy}};
        end
    end

    assign rdData           = bus.spi_rd_data;
    assign bus.req_rd_data  = rdData;
    assign bus.gnt          = gnt_q;
    assign bus.owner        = owner_q;
    assign bus.cmd_drop_err = err_q;

    always_ff @(posedge clk_20m) begin
        if (!rstn) begin
            state_q <= IDLE;
            owner_q <= OW'(NUM_REQ - 1);
            gnt_q   <= '0;
            guard_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            guard_q <= guard_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed plus randomized bench for spi_bus_arbiter; a tiny spi_master model drives busy/ncs
// and a round-robin reference picks the expected owner from the request masks.
module tb_spi_bus_arbiter;
    localparam int NR = 3;
    localparam int MW = 24;
    localparam int RW = 8;
    localparam int G  = 4;

    logic clk_20m = 1'b0;
    logic rstn;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;
    int frameLen   = 3;
    int frameCnt   = 0;
    logic [RW:0] rdVal;

    always #25 clk_20m = ~clk_20m;

    spi_bus_arbiter_if #(.NUM_REQ(NR), .MOSI_DATA_WIDTH(MW), .MISO_DATA_WIDTH(RW)) bus ();

    spi_bus_arbiter #(
        .NUM_REQ(NR), .MOSI_DATA_WIDTH(MW), .MISO_DATA_WIDTH(RW), .GUARD_CYCLES(G)
    ) dut (
        .clk_20m (clk_20m),
        .rstn    (rstn),
        .bus     (bus)
    );

    // spi_master stand-in: a command starts a frame of frameLen busy cycles with ncs low.
    always @(posedge clk_20m) begin
        if (!rstn) begin
            bus.spi_busy <= 1'b0;
            bus.spi_ncs  <= 1'b1;
            frameCnt     <= 0;
        end else if (frameCnt > 1) begin
            frameCnt <= frameCnt - 1;
        end else if (frameCnt == 1) begin
            frameCnt     <= 0;
            bus.spi_busy <= 1'b0;
            bus.spi_ncs  <= 1'b1;
        end else if (bus.spi_wr_cmd || bus.spi_rd_cmd) begin
            frameCnt     <= frameLen;
            bus.spi_busy <= 1'b1;
            bus.spi_ncs  <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_20m);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NR-1:0] reqV, input logic [NR-1:0] wr, input logic [NR-1:0] rd);
        bus.req        = reqV;
        bus.req_wr_cmd = wr;
        bus.req_rd_cmd = rd;
        #1;
    endtask

    task automatic resetDut();
        rstn = 1'b0;
        applyStimulus('0, '0, '0);
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Reference arbitration: first requester strictly after the last owner, wrapping.
    function automatic int rrPick(input int last, input logic [NR-1:0] mask);
        for (int k = 1; k <= NR; k++)
            if (mask[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    function automatic logic [NR-1:0] oneHot(input int idx);
        logic [NR-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic waitIdle(input int idx);
        int n = 0;
        while (bus.req_busy[idx] && n < 200) begin
            tick();
            n++;
        end
        checkOutput("bus_idle", 64'(bus.req_busy[idx]), 64'd0);
    endtask

    task automatic doWord(input int idx, input bit isRead, input int len);
        logic [MW-1:0] d;
        logic [NR-1:0] expCs;
        frameLen = len;
        waitIdle(idx);
        d = MW'($urandom);
        bus.req_wr_data[idx*MW +: MW] = d;
        if (isRead) bus.req_rd_cmd[idx] = 1'b1;
        else        bus.req_wr_cmd[idx] = 1'b1;
        #1;
        if (isRead) begin
            checkOutput("rd_issue", 64'(bus.spi_rd_cmd), 64'd1);
        end else begin
            checkOutput("wr_issue", 64'(bus.spi_wr_cmd), 64'd1);
            checkOutput("wr_data", 64'(bus.spi_wr_data), 64'(d));
        end
        tick();
        bus.req_wr_cmd = '0;
        bus.req_rd_cmd = '0;
        #1;
        expCs = ~oneHot(idx);
        checkOutput("cs_active", 64'(bus.dev_cs_n), 64'(expCs));
    endtask

    task automatic releaseBus(input int idx, input logic [NR-1:0] nextMask, output int gap, output bit csHigh);
        waitIdle(idx);
        bus.req[idx] = 1'b0;
        csHigh = 1'b1;
        tick();
        gap = 1;
        bus.req = nextMask;
        while (bus.gnt == '0 && gap < 100) begin
            if (bus.dev_cs_n != '1) csHigh = 1'b0;
            tick();
            gap++;
        end
    endtask

    initial begin
        int gap, cur, n;
        bit csOk;
        logic [NR-1:0] mask;

        rstn = 1'b0;
        rdVal = (RW+1)'($urandom);
        bus.spi_rd_data = rdVal;
        bus.req_wr_data = '0;
        applyStimulus('0, '0, '0);

        // Reset values
        resetDut();
        checkOutput("rst_gnt", 64'(bus.gnt), 64'd0);
        checkOutput("rst_cs", 64'(bus.dev_cs_n), 64'h7);
        checkOutput("rst_busy", 64'(bus.req_busy), 64'h7);
        checkOutput("rst_cmds", 64'({bus.spi_wr_cmd, bus.spi_rd_cmd}), 64'd0);
        checkOutput("rst_data", 64'(bus.spi_wr_data), 64'd0);
        checkOutput("rst_owner", 64'(bus.owner), 64'(NR-1));
        checkOutput("rst_err", 64'(bus.cmd_drop_err), 64'd0);

        // First grant, write of 0x000118, chip-select tracking
        applyStimulus(3'b001, '0, '0);
        checkOutput("gnt_latency_pre", 64'(bus.gnt), 64'd0);
        tick();
        checkOutput("gnt0", 64'(bus.gnt), 64'b001);
        checkOutput("owner0", 64'(bus.owner), 64'd0);
        checkOutput("cs_idle_owner", 64'(bus.dev_cs_n), 64'b111);
        checkOutput("busy_view", 64'(bus.req_busy), 64'b110);
        frameLen = 3;
        bus.req_wr_data[0 +: MW] = 24'h000118;
        bus.req_wr_cmd[0] = 1'b1;
        #1;
        checkOutput("wr_same_cycle", 64'(bus.spi_wr_cmd), 64'd1);
        checkOutput("wr_data_118", 64'(bus.spi_wr_data), 64'h000118);
        checkOutput("rd_quiet", 64'(bus.spi_rd_cmd), 64'd0);
        tick();
        bus.req_wr_cmd = '0;
        #1;
        checkOutput("cs_follow_low", 64'(bus.dev_cs_n), 64'b110);
        checkOutput("busy_follow", 64'(bus.req_busy), 64'b111);
        checkOutput("rd_broadcast", 64'(bus.req_rd_data), 64'(rdVal));
        waitIdle(0);
        checkOutput("cs_follow_high", 64'(bus.dev_cs_n), 64'b111);

        // Round robin with all three requesting
        resetDut();
        applyStimulus(3'b111, '0, '0);
        tick();
        checkOutput("rr_first", 64'(bus.gnt), 64'b001);
        cur = 0;
        for (int s = 0; s < 3; s++) begin
            doWord(cur, 1'b0, 2);
            releaseBus(cur, 3'b111, gap, csOk);
            cur = rrPick(cur, 3'b111);
            checkOutput("rr_order", 64'(bus.gnt), 64'(oneHot(cur)));
            checkOutput("rr_gap", 64'(gap), 64'(G + 3));
            checkOutput("rr_gap_cs", 64'(csOk), 64'd1);
        end

        // Release while spi_master is still busy: DRAIN holds until busy falls
        resetDut();
        applyStimulus(3'b010, '0, '0);
        tick();
        checkOutput("drain_gnt1", 64'(bus.gnt), 64'b010);
        doWord(1, 1'b0, 55);
        for (int i = 0; i < 5; i++) tick();
        bus.req = 3'b101;
        n = 0;
        csOk = 1'b1;
        while (bus.spi_busy && n < 200) begin
            tick();
            n++;
            if (bus.gnt != '0 || bus.dev_cs_n != {1'b1, bus.spi_ncs, 1'b1}) csOk = 1'b0;
        end
        checkOutput("drain_len", 64'(n), 64'd50);
        checkOutput("drain_cs_track", 64'(csOk), 64'd1);
        n = 0;
        while (bus.gnt == '0 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("drain_guard", 64'(n), 64'(G + 2));
        checkOutput("drain_next", 64'(bus.gnt), 64'(oneHot(rrPick(1, 3'b101))));

        // Non-owner command is discarded and flagged
        resetDut();
        applyStimulus(3'b001, '0, '0);
        tick();
        checkOutput("nonown_err_pre", 64'(bus.cmd_drop_err), 64'd0);
        bus.req_wr_cmd[2] = 1'b1;
        #1;
        checkOutput("nonown_no_cmd", 64'(bus.spi_wr_cmd), 64'd0);
        tick();
        bus.req_wr_cmd = '0;
        #1;
        checkOutput("nonown_err", 64'(bus.cmd_drop_err), 64'd1);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("nonown_sticky", 64'(bus.cmd_drop_err), 64'd1);
        checkOutput("nonown_gnt", 64'(bus.gnt), 64'b001);

        // Write and read together: write wins, read dropped
        resetDut();
        applyStimulus(3'b001, '0, '0);
        tick();
        applyStimulus(3'b001, 3'b001, 3'b001);
        checkOutput("both_wr", 64'(bus.spi_wr_cmd), 64'd1);
        checkOutput("both_rd", 64'(bus.spi_rd_cmd), 64'd0);
        tick();
        applyStimulus(3'b001, '0, '0);
        checkOutput("both_err", 64'(bus.cmd_drop_err), 64'd1);

        // Command while busy, then reset in the middle of the frame
        resetDut();
        applyStimulus(3'b001, '0, '0);
        tick();
        doWord(0, 1'b0, 10);
        checkOutput("busy_err_pre", 64'(bus.cmd_drop_err), 64'd0);
        bus.req_wr_cmd[0] = 1'b1;
        #1;
        checkOutput("busy_no_cmd", 64'(bus.spi_wr_cmd), 64'd0);
        tick();
        bus.req_wr_cmd = '0;
        #1;
        checkOutput("busy_err", 64'(bus.cmd_drop_err), 64'd1);
        checkOutput("midframe_cs", 64'(bus.dev_cs_n), 64'b110);
        rstn = 1'b0;
        tick();
        checkOutput("mrst_gnt", 64'(bus.gnt), 64'd0);
        checkOutput("mrst_cs", 64'(bus.dev_cs_n), 64'b111);
        checkOutput("mrst_owner", 64'(bus.owner), 64'd2);
        checkOutput("mrst_busy", 64'(bus.req_busy), 64'b111);
        checkOutput("mrst_err", 64'(bus.cmd_drop_err), 64'd0);
        rstn = 1'b1;
        applyStimulus(3'b110, '0, '0);
        tick();
        checkOutput("mrst_regrant", 64'(bus.gnt), 64'b010);

        // Randomized bursts against the round-robin reference
        resetDut();
        mask = NR'($urandom_range(1, 7));
        applyStimulus(mask, '0, '0);
        tick();
        cur = rrPick(NR - 1, mask);
        for (int it = 0; it < 12; it++) begin
            checkOutput("rnd_gnt", 64'(bus.gnt), 64'(oneHot(cur)));
            checkOutput("rnd_owner", 64'(bus.owner), 64'(cur));
            n = $urandom_range(1, 3);
            for (int w = 0; w < n; w++)
                doWord(cur, 1'($urandom_range(0, 1)), $urandom_range(1, 6));
            mask = NR'($urandom_range(1, 7));
            releaseBus(cur, mask, gap, csOk);
            checkOutput("rnd_gap", 64'(gap), 64'(G + 3));
            checkOutput("rnd_gap_cs", 64'(csOk), 64'd1);
            cur = rrPick(cur, mask);
        end
        checkOutput("rnd_no_err", 64'(bus.cmd_drop_err), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
